cache: RTL and testbench

// - Direct-mapped, write-back, write-allocate data cache between the CPU load/store path and the word-addressed D-memory.
// - Accepts one word request at a time. Returns read data, or merges byte-enabled write data.
// - Handles line fills and dirty evictions over the D_MEM_* bus. Reports progress with RDY/VALID.

---
 rtl/cache.sv | 205 ++++++++++++++++++++
 tb/tb_cache.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cache.sv
// Direct-mapped, write-back, write-allocate data cache.
// The CPU side takes one word request at a time; misses are served over the D_MEM_* bus.
// The bus behaves like a synchronous SRAM: read data arrives one cycle after its address.
module cache #(
  parameter int ADDR_W      = 12,
  parameter int DATA_W      = 32,
  parameter int INDEX_BITS  = 3,
  parameter int OFFSET_BITS = 2
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                Cache_CSN,
  input  logic                Cache_WEN,
  input  logic [ADDR_W-1:0]   Cache_ADDR,
  input  logic [DATA_W/8-1:0] Cache_BE,
  input  logic [DATA_W-1:0]   Cache_DI,
  output logic [DATA_W-1:0]   Cache_DOUT,
  output logic                RDY,
  output logic                VALID,
  output logic                D_MEM_CSN,
  output logic                D_MEM_WEN,
  output logic [ADDR_W-1:0]   D_MEM_ADDR,
  output logic [DATA_W/8-1:0] D_MEM_BE,
  output logic [DATA_W-1:0]   D_MEM_DOUT,
  input  logic [DATA_W-1:0]   D_MEM_DI
);

  localparam int BE_W     = DATA_W / 8;
  localparam int TAG_BITS = ADDR_W - INDEX_BITS - OFFSET_BITS;
  localparam int LINES    = 1 << INDEX_BITS;
  localparam int WORDS    = 1 << OFFSET_BITS;
  localparam int CNT_W    = OFFSET_BITS + 1;

  typedef enum logic [1:0] {IDLE, TAG, WB, FILL} state_t;

  state_t state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // Latched request
  logic [ADDR_W-1:0] addr_reg;
  logic              wen_reg;
  logic [BE_W-1:0]   be_reg;
  logic [DATA_W-1:0] di_reg;

  // Line state and storage
  logic [LINES-1:0]    valid_reg;
  logic [LINES-1:0]    dirty_reg;
  logic [TAG_BITS-1:0] tag_mem [LINES];
  logic [DATA_W-1:0]   data_mem [LINES*WORDS];
  logic [DATA_W-1:0]   dout_reg;

  logic [OFFSET_BITS-1:0] req_off;
  logic [INDEX_BITS-1:0]  req_idx;
  logic [TAG_BITS-1:0]    req_tag;
  logic                   hit;
  logic                   line_dirty;
  logic                   fill_last;
  logic [OFFSET_BITS-1:0] cnt_word;
  logic [OFFSET_BITS-1:0] fill_word;
  logic [DATA_W-1:0]      cur_word;
  logic [DATA_W-1:0]      merged_word;

  logic                              data_we;
  logic [INDEX_BITS+OFFSET_BITS-1:0] data_waddr;
  logic [DATA_W-1:0]                 data_wdata;

  assign req_off    = addr_reg[OFFSET_BITS-1:0];
  assign req_idx    = addr_reg[OFFSET_BITS +: INDEX_BITS];
  assign req_tag    = addr_reg[ADDR_W-1 -: TAG_BITS];
  assign hit        = valid_reg[req_idx] && (tag_mem[req_idx] == req_tag);
  assign line_dirty = valid_reg[req_idx] && dirty_reg[req_idx];
  assign fill_last  = (cnt_reg == CNT_W'(WORDS));
  assign cnt_word   = cnt_reg[OFFSET_BITS-1:0];
  // Word captured this cycle was addressed on the previous fill cycle
  assign fill_word  = cnt_word - OFFSET_BITS'(1);
  assign cur_word   = data_mem[{req_idx, req_off}];

  // Byte-enabled merge of write data into the addressed word
  generate
    for (genvar gi = 0; gi < BE_W; gi++) begin : g_merge
      assign merged_word[8*gi +: 8] = be_reg[gi] ? di_reg[8*gi +: 8] : cur_word[8*gi +: 8];
    end
  endgenerate

  // State register, burst counter, valid/dirty bits and held read data
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      valid_reg <= '0;
      dirty_reg <= '0;
      dout_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == TAG && hit) begin
        if (wen_reg) dout_reg <= cur_word;
        else         dirty_reg[req_idx] <= 1'b1;
      end
      if (state_reg == FILL && fill_last) begin
        valid_reg[req_idx] <= 1'b1;
        dirty_reg[req_idx] <= 1'b0;
      end
    end
  end

  // Next-state and counter logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: if (!Cache_CSN) state_next = TAG;
      TAG: begin
        cnt_next = '0;
        if (hit)             state_next = IDLE;
        else if (line_dirty) state_next = WB;
        else                 state_next = FILL;
      end
      WB: begin
        if (cnt_reg == CNT_W'(WORDS - 1)) begin
          state_next = FILL;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      FILL: begin
        if (fill_last) begin
          state_next = TAG;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Output decode; reset forces every output to its quiet value
  always_comb begin
    Cache_DOUT = dout_reg;
    RDY        = 1'b0;
    VALID      = 1'b0;
    D_MEM_CSN  = 1'b1;
    D_MEM_WEN  = 1'b1;
    D_MEM_BE   = '1;
    D_MEM_ADDR = '0;
    D_MEM_DOUT = '0;
    if (!RSTn) begin
      Cache_DOUT = '0;
    end else begin
      case (state_reg)
        IDLE: RDY = 1'b1;
        TAG: begin
          if (hit) begin
            VALID = 1'b1;
            if (wen_reg) Cache_DOUT = cur_word;
          end
        end
        WB: begin
          D_MEM_CSN  = 1'b0;
          D_MEM_WEN  = 1'b0;
          D_MEM_ADDR = {tag_mem[req_idx], req_idx, cnt_word};
          D_MEM_DOUT = data_mem[{req_idx, cnt_word}];
        end
        FILL: begin
          if (!fill_last) begin
            D_MEM_CSN  = 1'b0;
            D_MEM_ADDR = {req_tag, req_idx, cnt_word};
          end
        end
        default: ;
      endcase
    end
  end

  // Data array write port: write-hit merge or fill capture
  always_comb begin
    data_we    = 1'b0;
    data_waddr = {req_idx, req_off};
    data_wdata = merged_word;
    if (RSTn) begin
      if (state_reg == TAG && hit && !wen_reg) begin
        data_we = 1'b1;
      end else if (state_reg == FILL && cnt_reg != '0) begin
        data_we    = 1'b1;
        data_waddr = {req_idx, fill_word};
        data_wdata = D_MEM_DI;
      end
    end
  end

  // Request latch, tag array and data array (no reset needed)
  always_ff @(posedge CLK) begin
    if (state_reg == IDLE && !Cache_CSN) begin
      addr_reg <= Cache_ADDR;
      wen_reg  <= Cache_WEN;
      be_reg   <= Cache_BE;
      di_reg   <= Cache_DI;
    end
    if (data_we) data_mem[data_waddr] <= data_wdata;
    if (RSTn && state_reg == FILL && fill_last) tag_mem[req_idx] <= req_tag;
  end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for cache: table of directed requests plus hand-written
// sequences for the ignored mid-writeback request and a reset during a fill.
module tb_cache;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        Cache_CSN;
  logic        Cache_WEN;
  logic [11:0] Cache_ADDR;
  logic [3:0]  Cache_BE;
  logic [31:0] Cache_DI;
  logic [31:0] Cache_DOUT;
  logic        RDY;
  logic        VALID;
  logic        D_MEM_CSN;
  logic        D_MEM_WEN;
  logic [11:0] D_MEM_ADDR;
  logic [3:0]  D_MEM_BE;
  logic [31:0] D_MEM_DOUT;
  logic [31:0] D_MEM_DI;

  cache dut (
    .CLK(CLK), .RSTn(RSTn),
    .Cache_CSN(Cache_CSN), .Cache_WEN(Cache_WEN), .Cache_ADDR(Cache_ADDR),
    .Cache_BE(Cache_BE), .Cache_DI(Cache_DI), .Cache_DOUT(Cache_DOUT),
    .RDY(RDY), .VALID(VALID),
    .D_MEM_CSN(D_MEM_CSN), .D_MEM_WEN(D_MEM_WEN), .D_MEM_ADDR(D_MEM_ADDR),
    .D_MEM_BE(D_MEM_BE), .D_MEM_DOUT(D_MEM_DOUT), .D_MEM_DI(D_MEM_DI)
  );

  always #5 CLK = ~CLK;

  // Synchronous SRAM model with access logs
  logic [31:0] mem [0:4095];
  logic [31:0] rd_q;
  logic [11:0] wr_log [0:255];
  logic [11:0] rd_log [0:255];
  int          wr_total = 0;
  int          rd_total = 0;
  assign D_MEM_DI = rd_q;

  always @(posedge CLK) begin
    logic [31:0] w;
    if (!D_MEM_CSN) begin
      if (!D_MEM_WEN) begin
        w = mem[D_MEM_ADDR];
        for (int b = 0; b < 4; b++)
          if (D_MEM_BE[b]) w[8*b +: 8] = D_MEM_DOUT[8*b +: 8];
        mem[D_MEM_ADDR] <= w;
        wr_log[wr_total[7:0]] <= D_MEM_ADDR;
        wr_total <= wr_total + 1;
      end else begin
        rd_q <= mem[D_MEM_ADDR];
        rd_log[rd_total[7:0]] <= D_MEM_ADDR;
        rd_total <= rd_total + 1;
      end
    end
  end

  typedef struct {
    bit          wen;     // 1 = read
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] di;
    int          lat;
    logic [31:0] dout;    // expected read data
    int          nwr;
    logic [11:0] wr_base;
    int          nrd;
    logic [11:0] rd_base;
    bit          noise;   // hold a stray request on the bus while busy
  } vec_t;

  vec_t        vecs [13];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_read = 32'h0;

  task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%h required=%h", name, id, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int wr_start, rd_start, lat, n;
    bit seq_ok;
    n = 0;
    while (!RDY && n < 20) begin @(negedge CLK); n++; end
    chk("rdy_before_req", id, 32'(RDY), 32'd1);
    wr_start = wr_total;
    rd_start = rd_total;
    Cache_CSN = 1'b0; Cache_WEN = v.wen; Cache_ADDR = v.addr; Cache_BE = v.be; Cache_DI = v.di;
    @(negedge CLK);
    if (v.noise) begin
      Cache_CSN = 1'b0; Cache_WEN = 1'b1; Cache_ADDR = 12'h000; Cache_BE = 4'hF;
    end else begin
      Cache_CSN = 1'b1; Cache_ADDR = 12'($urandom); Cache_DI = $urandom; Cache_BE = 4'($urandom);
    end
    lat = 1;
    while (!VALID && lat < 40) begin @(negedge CLK); lat++; end
    Cache_CSN = 1'b1;
    chk("latency", id, 32'(lat), 32'(v.lat));
    if (v.wen) begin
      chk("read_data", id, Cache_DOUT, v.dout);
      last_read = v.dout;
    end
    $display("vec %0d %s addr=%h latency=%0d dout=%h", id, v.wen ? "RD" : "WR", v.addr, lat, Cache_DOUT);
    chk("mem_writes", id, 32'(wr_total - wr_start), 32'(v.nwr));
    chk("mem_reads", id, 32'(rd_total - rd_start), 32'(v.nrd));
    seq_ok = 1'b1;
    for (int i = 0; i < v.nwr && i < wr_total - wr_start; i++)
      if (wr_log[8'(wr_start + i)] !== v.wr_base + 12'(i)) seq_ok = 1'b0;
    for (int i = 0; i < v.nrd && i < rd_total - rd_start; i++)
      if (rd_log[8'(rd_start + i)] !== v.rd_base + 12'(i)) seq_ok = 1'b0;
    chk("mem_addr_seq", id, 32'(seq_ok), 32'd1);
    @(negedge CLK);
    chk("valid_pulse", id, 32'(VALID), 32'd0);
    chk("dout_hold", id, Cache_DOUT, last_read);
  endtask

  initial begin
    int ws, rs;
    for (int a = 0; a < 4096; a++) mem[a] = 32'h1000_0000 + 32'(a);
    //             wen  addr    be    di            lat dout          nwr wrb     nrd rdb     noise
    vecs[0]  = '{1'b1, 12'h010, 4'hF, 32'h0,         7, 32'h1000_0010, 0, 12'h0,   4, 12'h010, 1'b0};
    vecs[1]  = '{1'b1, 12'h011, 4'hF, 32'h0,         1, 32'h1000_0011, 0, 12'h0,   0, 12'h0,   1'b0};
    vecs[2]  = '{1'b0, 12'h012, 4'h3, 32'hAABB_CCDD, 1, 32'h0,         0, 12'h0,   0, 12'h0,   1'b0};
    vecs[3]  = '{1'b1, 12'h012, 4'h0, 32'h0,         1, 32'h1000_CCDD, 0, 12'h0,   0, 12'h0,   1'b0};
    vecs[4]  = '{1'b0, 12'h013, 4'h0, 32'hFFFF_FFFF, 1, 32'h0,         0, 12'h0,   0, 12'h0,   1'b0};
    vecs[5]  = '{1'b1, 12'h013, 4'hF, 32'h0,         1, 32'h1000_0013, 0, 12'h0,   0, 12'h0,   1'b0};
    vecs[6]  = '{1'b1, 12'h030, 4'hF, 32'h0,        11, 32'h1000_0030, 4, 12'h010, 4, 12'h030, 1'b1};
    vecs[7]  = '{1'b1, 12'h031, 4'hF, 32'h0,         1, 32'h1000_0031, 0, 12'h0,   0, 12'h0,   1'b0};
    vecs[8]  = '{1'b0, 12'h035, 4'hF, 32'h1234_5678, 7, 32'h0,         0, 12'h0,   4, 12'h034, 1'b0};
    vecs[9]  = '{1'b1, 12'h035, 4'hF, 32'h0,         1, 32'h1234_5678, 0, 12'h0,   0, 12'h0,   1'b0};
    vecs[10] = '{1'b1, 12'h012, 4'hF, 32'h0,         7, 32'h1000_CCDD, 0, 12'h0,   4, 12'h010, 1'b0};
    vecs[11] = '{1'b0, 12'h010, 4'hF, 32'hDEAD_BEEF, 1, 32'h0,         0, 12'h0,   0, 12'h0,   1'b0};
    vecs[12] = '{1'b1, 12'h030, 4'hF, 32'h0,         7, 32'h1000_0030, 0, 12'h0,   4, 12'h030, 1'b0};

    RSTn = 1'b0; Cache_CSN = 1'b1; Cache_WEN = 1'b1; Cache_ADDR = '0; Cache_BE = 4'hF; Cache_DI = '0;
    repeat (3) @(negedge CLK);
    chk("reset_rdy", -1, 32'(RDY), 32'd0);
    chk("reset_bus", -1, {VALID, D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR}, {1'b0, 1'b1, 1'b1, 4'hF, 12'h000});
    chk("reset_data", -1, Cache_DOUT | D_MEM_DOUT, 32'h0);
    RSTn = 1'b1;
    #1;
    chk("idle_rdy", -1, 32'(RDY), 32'd1);
    chk("idle_dout", -1, Cache_DOUT, 32'h0);

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], i);
      if (i == 6) begin
        // The stray 0x000 request held during the writeback must not start a transaction
        ws = wr_total; rs = rd_total;
        for (int c = 0; c < 3; c++) begin
          chk("no_extra_valid", i, 32'(VALID), 32'd0);
          chk("idle_after_evict", i, 32'(RDY), 32'd1);
          @(negedge CLK);
        end
        chk("no_extra_mem", i, 32'(wr_total - ws + rd_total - rs), 32'd0);
        chk("wb_word2", i, mem[12'h012], 32'h1000_CCDD);
        chk("wb_word3", i, mem[12'h013], 32'h1000_0013);
      end
    end

    // Dirty miss on 0x030, then reset while the fill is in progress
    Cache_CSN = 1'b0; Cache_WEN = 1'b1; Cache_ADDR = 12'h030; Cache_BE = 4'hF;
    @(negedge CLK);
    Cache_CSN = 1'b1;
    for (int c = 1; c < 7; c++) @(negedge CLK);
    chk("mid_fill_read", 13, {D_MEM_CSN, D_MEM_WEN}, {1'b0, 1'b1});
    RSTn = 1'b0;
    #1;
    chk("reset_out_rdy_valid", 13, {RDY, VALID}, 2'b00);
    chk("reset_out_bus", 13, {D_MEM_CSN, D_MEM_WEN, D_MEM_BE, D_MEM_ADDR}, {1'b1, 1'b1, 4'hF, 12'h000});
    chk("reset_out_data", 13, Cache_DOUT | D_MEM_DOUT, 32'h0);
    @(negedge CLK);
    RSTn = 1'b1;
    #1;
    chk("rdy_after_reset", 13, 32'(RDY), 32'd1);
    chk("wb_before_reset", 13, mem[12'h010], 32'hDEAD_BEEF);
    last_read = 32'h0;
    run_vec(vecs[12], 12);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "timeout");
  end

endmodule
